// File: rtl/scc_pkg.sv
// scc_pkg: shared opcodes, instruction field positions, widths and reset PC for the scc core
package scc_pkg;
    localparam int XLEN = 32;
    localparam int NREG = 16;
    localparam int RW = $clog2(NREG);
    localparam logic [XLEN-1:0] RESET_PC = '0;
    localparam int OP_LO = 28;
    localparam int RD_LO = 24;
    localparam int RS1_LO = 20;
    localparam int RS2_LO = 16;
    localparam int IMM_W = 16;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_ADD   = 4'h1,
        OP_SUB   = 4'h2,
        OP_AND   = 4'h3,
        OP_OR    = 4'h4,
        OP_XOR   = 4'h5,
        OP_ADDI  = 4'h6,
        OP_MOVI  = 4'h7,
        OP_LOAD  = 4'h8,
        OP_STORE = 4'h9,
        OP_BEQ   = 4'hA,
        OP_BNE   = 4'hB,
        OP_JMP   = 4'hC,
        OP_SLL   = 4'hD,
        OP_SRL   = 4'hE,
        OP_HALT  = 4'hF
    } opcode_t;

    function automatic logic [XLEN-1:0] sext16(input logic [IMM_W-1:0] imm);
        return {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction
endpackage

// File: rtl/scc_regfile.sv
// scc_regfile: 16x32 register file, R0 reads as zero, two combinational reads, one clocked write
module scc_regfile
    import scc_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [RW-1:0]   ra1,
    input  logic [RW-1:0]   ra2,
    input  logic [RW-1:0]   wa,
    input  logic            we,
    input  logic [XLEN-1:0] wd,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2
);
    logic [XLEN-1:0] regs [NREG];

    // clear everything on reset, otherwise commit the single write port (R0 is never written)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (we && wa != '0) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
    assign rd2 = (ra2 == '0) ? '0 : regs[ra2];
endmodule

// File: rtl/scc.sv
// scc: single-cycle 32-bit core; define SCC_SHIFT_EN to enable SLL/SRL (otherwise they act as NOP)
module scc
    import scc_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] in_mem,
    input  logic [XLEN-1:0] data_in,
    output logic [XLEN-1:0] in_mem_addr,
    output logic            in_mem_en,
    output logic [XLEN-1:0] data_addr,
    output logic [XLEN-1:0] data_out,
    output logic            data_read,
    output logic            data_write
);
    logic [XLEN-1:0] pc, next_pc, pc_plus4, br_tgt, imm, ea, rs1_v, rs2_v, res;
    logic            halt, active, wr;
    opcode_t         op;

    assign op       = opcode_t'(in_mem[OP_LO +: 4]);
    assign imm      = sext16(in_mem[IMM_W-1:0]);
    assign active   = !reset && !halt;
    assign pc_plus4 = pc + 32'd4;
    assign br_tgt   = pc_plus4 + (imm << 2);
    assign ea       = rs1_v + imm;

    scc_regfile u_rf (
        .clk  (clk),
        .reset(reset),
        .ra1  (in_mem[RS1_LO +: RW]),
        .ra2  (in_mem[RS2_LO +: RW]),
        .wa   (in_mem[RD_LO +: RW]),
        .we   (active && wr),
        .wd   (res),
        .rd1  (rs1_v),
        .rd2  (rs2_v)
    );

    // decode and execute: writeback value, write enable and next PC
    always_comb begin
        res = '0;
        wr = 1'b0;
        next_pc = pc_plus4;
        case (op)
            OP_ADD:  begin res = rs1_v + rs2_v; wr = 1'b1; end
            OP_SUB:  begin res = rs1_v - rs2_v; wr = 1'b1; end
            OP_AND:  begin res = rs1_v & rs2_v; wr = 1'b1; end
            OP_OR:   begin res = rs1_v | rs2_v; wr = 1'b1; end
            OP_XOR:  begin res = rs1_v ^ rs2_v; wr = 1'b1; end
            OP_ADDI: begin res = ea; wr = 1'b1; end
            OP_MOVI: begin res = imm; wr = 1'b1; end
            OP_LOAD: begin res = data_in; wr = 1'b1; end
            OP_BEQ:  next_pc = (rs1_v == rs2_v) ? br_tgt : pc_plus4;
            OP_BNE:  next_pc = (rs1_v != rs2_v) ? br_tgt : pc_plus4;
            OP_JMP:  next_pc = br_tgt;
`ifdef SCC_SHIFT_EN
            OP_SLL:  begin res = rs1_v << rs2_v[4:0]; wr = 1'b1; end
            OP_SRL:  begin res = rs1_v >> rs2_v[4:0]; wr = 1'b1; end
`endif
            OP_HALT: next_pc = pc;
            default: ;
        endcase
    end

    // PC and halt flag; once halted nothing changes until reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
            halt <= 1'b0;
        end else if (!halt) begin
            pc <= next_pc;
            halt <= (op == OP_HALT);
        end
    end

    assign in_mem_addr = pc;
    assign in_mem_en   = active;
    assign data_read   = active && op == OP_LOAD;
    assign data_write  = active && op == OP_STORE;
    assign data_addr   = (data_read || data_write) ? ea : '0;
    assign data_out    = data_write ? rs2_v : '0;
endmodule

// File: tb/tb_scc.sv
// tb_scc: directed program table, halt/reset sequences and a random run against a behavioural ISA model
module tb_scc;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] in_mem = '0;
    logic [31:0] data_in = '0;
    logic [31:0] in_mem_addr, data_addr, data_out;
    logic        in_mem_en, data_read, data_write;

`ifdef SCC_SHIFT_EN
    localparam bit SH = 1'b1;
`else
    localparam bit SH = 1'b0;
`endif

    typedef struct {
        logic [31:0] instr;
        logic [31:0] din;
        logic [31:0] addr;
        logic        en;
        logic [31:0] da;
        logic [31:0] dout;
        logic        rd;
        logic        wr;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    scc dut (
        .clk        (clk),
        .reset      (reset),
        .in_mem     (in_mem),
        .data_in    (data_in),
        .in_mem_addr(in_mem_addr),
        .in_mem_en  (in_mem_en),
        .data_addr  (data_addr),
        .data_out   (data_out),
        .data_read  (data_read),
        .data_write (data_write)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [31:0] i, input logic [31:0] d, input logic [31:0] a,
                                input logic [31:0] da, input logic [31:0] dout, input logic rd, input logic wr);
        vec_t v;
        v.instr = i; v.din = d; v.addr = a; v.en = 1'b1; v.da = da; v.dout = dout; v.rd = rd; v.wr = wr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] a, input logic en,
                         input logic [31:0] da, input logic [31:0] dout, input logic rd, input logic wr);
        n_vec++;
        if ({in_mem_addr, in_mem_en, data_addr, data_out, data_read, data_write} !== {a, en, da, dout, rd, wr}) begin
            n_err++;
            $display("FAIL %s: got addr=%h en=%b da=%h do=%h rd=%b wr=%b, want addr=%h en=%b da=%h do=%h rd=%b wr=%b",
                     name, in_mem_addr, in_mem_en, data_addr, data_out, data_read, data_write, a, en, da, dout, rd, wr);
        end
    endtask

    // apply one instruction, check the combinational outputs mid-cycle, then let the edge commit it
    task automatic step(input string name, input vec_t v);
        in_mem = v.instr;
        data_in = v.din;
        #1;
        check(name, v.addr, v.en, v.da, v.dout, v.rd, v.wr);
        @(posedge clk);
        #1;
    endtask

    // reference model state for the random run
    logic [31:0] m_r [16];
    logic [31:0] m_pc;

    initial begin
        tbl.push_back(mk(32'h7105_0005, 0, 32'h00, 0, 0, 0, 0));
        tbl.push_back(mk(32'h7200_FFFD, 0, 32'h04, 0, 0, 0, 0));
        tbl.push_back(mk(32'h1312_0000, 0, 32'h08, 0, 0, 0, 0));
        tbl.push_back(mk(32'h2412_0000, 0, 32'h0C, 0, 0, 0, 0));
        tbl.push_back(mk(32'h9003_0040, 0, 32'h10, 32'h40, 32'd2, 0, 1));
        tbl.push_back(mk(32'h9004_0044, 0, 32'h14, 32'h44, 32'd8, 0, 1));
        tbl.push_back(mk(32'h9001_0040, 0, 32'h18, 32'h40, 32'd5, 0, 1));
        tbl.push_back(mk(32'h8510_0010, 32'hDEAD_BEEF, 32'h1C, 32'h15, 0, 1, 0));
        tbl.push_back(mk(32'hA011_0002, 0, 32'h20, 0, 0, 0, 0));
        tbl.push_back(mk(32'h9005_0000, 0, 32'h2C, 0, 32'hDEAD_BEEF, 0, 1));
        tbl.push_back(mk(32'hB011_0005, 0, 32'h30, 0, 0, 0, 0));
        tbl.push_back(mk(32'hB012_0001, 0, 32'h34, 0, 0, 0, 0));
        tbl.push_back(mk(32'h7000_0007, 0, 32'h3C, 0, 0, 0, 0));
        tbl.push_back(mk(32'h1600_0000, 0, 32'h40, 0, 0, 0, 0));
        tbl.push_back(mk(32'h9006_0008, 0, 32'h44, 32'h8, 0, 0, 1));
        tbl.push_back(mk(32'hC000_FFFF, 0, 32'h48, 0, 0, 0, 0));
        tbl.push_back(mk(32'h7800_0004, 0, 32'h48, 0, 0, 0, 0));
        tbl.push_back(mk(32'hD718_0000, 0, 32'h4C, 0, 0, 0, 0));
        tbl.push_back(mk(32'h9007_0000, 0, 32'h50, 0, SH ? 32'd80 : 32'd0, 0, 1));
        tbl.push_back(mk(32'h7900_8000, 0, 32'h54, 0, 0, 0, 0));
        tbl.push_back(mk(32'hEA98_0000, 0, 32'h58, 0, 0, 0, 0));
        tbl.push_back(mk(32'h900A_0000, 0, 32'h5C, 0, SH ? 32'h0FFF_F800 : 32'd0, 0, 1));
        tbl.push_back(mk(32'h5B12_0000, 0, 32'h60, 0, 0, 0, 0));
        tbl.push_back(mk(32'h901B_FFFF, 0, 32'h64, 32'h4, 32'hFFFF_FFF8, 0, 1));
        tbl.push_back(mk(32'hF000_0000, 0, 32'h68, 0, 0, 0, 0));

        in_mem = 32'h9001_0040;
        #12;
        check("reset_outputs", 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        foreach (tbl[k]) step($sformatf("tbl%0d", k), tbl[k]);

        for (int k = 0; k < 5; k++) begin
            in_mem = 32'h9001_0040;
            @(posedge clk);
            #1;
            check($sformatf("halt%0d", k), 32'h68, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        end

        #2;
        reset = 1'b1;
        #1;
        check("async_reset", 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("after_reset", 32'h0, 1'b1, 32'h40, 32'h0, 1'b0, 1'b1);

        for (int i = 0; i < 16; i++) m_r[i] = '0;
        m_pc = '0;
        for (int n = 0; n < 400; n++) begin
            logic [3:0]  op, rd, a, b;
            logic [15:0] imm16;
            logic [31:0] x, y, s, d, val, ea;
            logic        w;
            op = ($urandom_range(0, 3) == 0) ? 4'h9 : 4'($urandom_range(0, 14));
            rd = 4'($urandom_range(0, 15));
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            imm16 = 16'($urandom);
            d = $urandom;
            x = m_r[a];
            y = m_r[b];
            s = {{16{imm16[15]}}, imm16};
            ea = x + s;
            in_mem = {op, rd, a, b, imm16};
            data_in = d;
            #1;
            check($sformatf("rand%0d", n), m_pc, 1'b1, (op == 4'h8 || op == 4'h9) ? ea : 32'h0,
                  (op == 4'h9) ? y : 32'h0, op == 4'h8, op == 4'h9);
            w = 1'b1;
            val = '0;
            case (op)
                4'h1: val = x + y;
                4'h2: val = x - y;
                4'h3: val = x & y;
                4'h4: val = x | y;
                4'h5: val = x ^ y;
                4'h6: val = ea;
                4'h7: val = s;
                4'h8: val = d;
                4'hD: begin w = SH; val = x << y[4:0]; end
                4'hE: begin w = SH; val = x >> y[4:0]; end
                default: w = 1'b0;
            endcase
            if (w && rd != 0) m_r[rd] = val;
            if (op == 4'hC || (op == 4'hA && x == y) || (op == 4'hB && x != y))
                m_pc = m_pc + 4 + (s << 2);
            else
                m_pc = m_pc + 4;
            @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
